// File: rtl/compressed_packer.sv
// Packs pairs of variable-length compressed words into fixed-width lines.
// Lines are emitted LSB-first; the final partial line of a packet is zero-padded.
module compressed_packer #(
  parameter int OUT_WIDTH  = 128,
  parameter int CODE_WIDTH = 34
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CODE_WIDTH-1:0] i_code1,
  input  logic [CODE_WIDTH-1:0] i_code2,
  input  logic [5:0]            i_length1,
  input  logic [5:0]            i_length2,
  input  logic                  i_last,
  output logic [OUT_WIDTH-1:0]  o_line,
  output logic                  o_line_valid,
  input  logic                  i_line_ready,
  output logic                  o_line_last,
  output logic [15:0]           o_pkt_bits,
  output logic                  o_len_err
);

  localparam int ACC_W  = 2 * OUT_WIDTH;
  localparam int FILL_W = $clog2(ACC_W);
  localparam logic [5:0]        MAX_LEN   = 6'(CODE_WIDTH);
  localparam logic [FILL_W-1:0] LINE_FILL = FILL_W'(OUT_WIDTH);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    if (len > MAX_LEN) begin
      return MAX_LEN;
    end else begin
      return len;
    end
  endfunction

  // Zero every bit at or above len so stale upper bits never reach the accumulator.
  function automatic logic [ACC_W-1:0] mask_code(input logic [CODE_WIDTH-1:0] code,
                                                 input logic [5:0] len);
    logic [ACC_W-1:0] m;
    m = '0;
    for (int i = 0; i < CODE_WIDTH; i++) begin
      if (6'(i) < len) begin
        m[i] = code[i];
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  state_t            state_r, state_s;
  logic [ACC_W-1:0]  acc_r, acc_s;
  logic [FILL_W-1:0] fill_r, fill_s;
  logic              pending_last_r, pending_last_s;
  logic [15:0]       pkt_bits_r, pkt_bits_s;
  logic              len_err_r, len_err_s;

  logic [5:0]        len1_s, len2_s;
  logic              accept_s;
  logic              line_last_s;
  logic [FILL_W-1:0] sum_fill_s;
  logic [16:0]       pkt_sum_s;
  logic [ACC_W-1:0]  placed_s;

  assign len1_s     = clamp_len(i_length1);
  assign len2_s     = clamp_len(i_length2);
  assign o_ready    = (state_r == ACCUM) && (fill_r < LINE_FILL) && i_reset;
  assign accept_s   = i_valid && o_ready;
  assign sum_fill_s = fill_r + FILL_W'(len1_s) + FILL_W'(len2_s);
  assign pkt_sum_s  = {1'b0, pkt_bits_r} + 17'(len1_s) + 17'(len2_s);
  assign placed_s   = acc_r
                    | (mask_code(i_code1, len1_s) << fill_r)
                    | (mask_code(i_code2, len2_s) << (fill_r + FILL_W'(len1_s)));

  // Output decode from the registered state and accumulator.
  always_comb begin
    o_line_valid = 1'b0;
    o_line       = '0;
    line_last_s  = 1'b0;
    if (state_r == FLUSH) begin
      o_line_valid = 1'b1;
      o_line       = acc_r[OUT_WIDTH-1:0];
      line_last_s  = 1'b1;
    end else if (state_r == DRAIN) begin
      o_line_valid = 1'b1;
      o_line       = acc_r[OUT_WIDTH-1:0];
      line_last_s  = pending_last_r && (fill_r == LINE_FILL);
    end else begin
      o_line_valid = 1'b0;
      o_line       = '0;
      line_last_s  = 1'b0;
    end
  end

  assign o_line_last = line_last_s;
  assign o_pkt_bits  = pkt_bits_r;
  assign o_len_err   = len_err_r;

  // Next-state and datapath update for accept and line handshakes.
  always_comb begin
    state_s        = state_r;
    acc_s          = acc_r;
    fill_s         = fill_r;
    pending_last_s = pending_last_r;
    pkt_bits_s     = pkt_bits_r;
    len_err_s      = len_err_r;
    case (state_r)
      ACCUM: begin
        if (accept_s) begin
          acc_s      = placed_s;
          fill_s     = sum_fill_s;
          pkt_bits_s = pkt_sum_s[16] ? 16'hFFFF : pkt_sum_s[15:0];
          if ((i_length1 > MAX_LEN) || (i_length2 > MAX_LEN)) begin
            len_err_s = 1'b1;
          end else begin
            len_err_s = len_err_r;
          end
          if (sum_fill_s >= LINE_FILL) begin
            state_s        = DRAIN;
            pending_last_s = i_last;
          end else if (i_last) begin
            state_s = FLUSH;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DRAIN: begin
        if (i_line_ready) begin
          acc_s  = acc_r >> OUT_WIDTH;
          fill_s = fill_r - LINE_FILL;
          // A packet ending exactly on a line boundary needs no flush line.
          if (line_last_s) begin
            state_s        = ACCUM;
            pending_last_s = 1'b0;
            pkt_bits_s     = 16'd0;
          end else if (pending_last_r) begin
            state_s = FLUSH;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      FLUSH: begin
        if (i_line_ready) begin
          acc_s          = '0;
          fill_s         = '0;
          pending_last_s = 1'b0;
          pkt_bits_s     = 16'd0;
          state_s        = ACCUM;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = ACCUM;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r        <= ACCUM;
      acc_r          <= '0;
      fill_r         <= '0;
      pending_last_r <= 1'b0;
      pkt_bits_r     <= 16'd0;
      len_err_r      <= 1'b0;
    end else begin
      state_r        <= state_s;
      acc_r          <= acc_s;
      fill_r         <= fill_s;
      pending_last_r <= pending_last_s;
      pkt_bits_r     <= pkt_bits_s;
      len_err_r      <= len_err_s;
    end
  end

endmodule

// File: tb/tb_compressed_packer.sv
// Scoreboard bench for compressed_packer: a bit-stream reference model queues expected
// lines at stimulus time and a negedge monitor compares every line handshake.
module tb_compressed_packer;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_valid;
  logic         o_ready;
  logic [33:0]  i_code1, i_code2;
  logic [5:0]   i_length1, i_length2;
  logic         i_last;
  logic [127:0] o_line;
  logic         o_line_valid;
  logic         i_line_ready;
  logic         o_line_last;
  logic [15:0]  o_pkt_bits;
  logic         o_len_err;

  always #5 i_clk = ~i_clk;

  compressed_packer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_code1(i_code1), .i_code2(i_code2), .i_length1(i_length1), .i_length2(i_length2),
    .i_last(i_last), .o_line(o_line), .o_line_valid(o_line_valid),
    .i_line_ready(i_line_ready), .o_line_last(o_line_last), .o_pkt_bits(o_pkt_bits),
    .o_len_err(o_len_err)
  );

  typedef struct packed {
    logic [127:0] line;
    logic         last;
    logic [15:0]  pkt;
  } exp_t;

  exp_t   exp_q[$];
  bit     bitq[$];
  int     pkt_cnt = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  exp_t   mon_e;
  logic [127:0] line_cap;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: a plain bit stream cut into 128-bit lines.
  task automatic model_beat(input logic [33:0] c1, input logic [33:0] c2,
                            input logic [5:0] l1, input logic [5:0] l2, input logic last);
    int   n1 = (l1 > 6'd34) ? 34 : int'(l1);
    int   n2 = (l2 > 6'd34) ? 34 : int'(l2);
    int   lines_this = 0;
    int   rem;
    exp_t e;
    for (int i = 0; i < n1; i++) bitq.push_back(c1[i]);
    for (int i = 0; i < n2; i++) bitq.push_back(c2[i]);
    pkt_cnt = pkt_cnt + n1 + n2;
    if (pkt_cnt > 65535) pkt_cnt = 65535;
    while (bitq.size() >= 128) begin
      e.line = '0;
      for (int i = 0; i < 128; i++) e.line[i] = bitq.pop_front();
      e.last = last && (bitq.size() == 0);
      e.pkt  = 16'(pkt_cnt);
      exp_q.push_back(e);
      lines_this++;
    end
    if (last && (bitq.size() != 0 || lines_this == 0)) begin
      e.line = '0;
      rem = bitq.size();
      for (int i = 0; i < rem; i++) e.line[i] = bitq.pop_front();
      e.last = 1'b1;
      e.pkt  = 16'(pkt_cnt);
      exp_q.push_back(e);
    end
    if (last) pkt_cnt = 0;
  endtask

  task automatic send_beat(input logic [33:0] c1, input logic [33:0] c2,
                           input logic [5:0] l1, input logic [5:0] l2, input logic last);
    int t = 0;
    model_beat(c1, c2, l1, l2, last);
    i_code1 = c1; i_code2 = c2; i_length1 = l1; i_length2 = l2; i_last = last;
    i_valid = 1'b1;
    while (!o_ready && t < 100) begin
      @(posedge i_clk); #1;
      t++;
    end
    chk("accept_ready", 128'(o_ready), 128'(1));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    chk("drain_pending", 128'(exp_q.size()), 128'(0));
    @(posedge i_clk); #1;
  endtask

  // Monitor: every line handshake is checked against the scoreboard head.
  always @(negedge i_clk) begin
    if (i_reset === 1'b1 && o_line_valid && i_line_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_line: got line %h, expected none", o_line);
      end else begin
        mon_e = exp_q.pop_front();
        chk("line_data", o_line, mon_e.line);
        chk("line_last", 128'(o_line_last), 128'(mon_e.last));
        if (mon_e.last) chk("pkt_bits", 128'(o_pkt_bits), 128'(mon_e.pkt));
      end
    end
  end

  logic [5:0] tl1 [10] = '{6'd34, 6'd0, 6'd33, 6'd5, 6'd34, 6'd20, 6'd0, 6'd12, 6'd34, 6'd31};
  logic [5:0] tl2 [10] = '{6'd1, 6'd17, 6'd34, 6'd0, 6'd34, 6'd30, 6'd0, 6'd34, 6'd2, 6'd31};

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_code1 = '0; i_code2 = '0;
    i_length1 = '0; i_length2 = '0; i_last = 1'b0; i_line_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", 128'(o_ready), 128'(0));
    chk("rst_line_valid", 128'(o_line_valid), 128'(0));
    chk("rst_line_last", 128'(o_line_last), 128'(0));
    chk("rst_line", o_line, 128'd0);
    chk("rst_pkt_bits", 128'(o_pkt_bits), 128'(0));
    chk("rst_len_err", 128'(o_len_err), 128'(0));
    i_reset = 1'b1;
    #1;
    chk("ready_after_release", 128'(o_ready), 128'(1));
    @(posedge i_clk); #1;

    // Four 34-bit words: one full line, then an 8-bit flush line (136 bits).
    send_beat(34'h2_DEAD_BEEF, 34'h1_2345_6789, 6'd34, 6'd34, 1'b0);
    send_beat(34'h3_0F0F_0F0F, 34'h0_FFFF_0000, 6'd34, 6'd34, 1'b1);
    chk("drain_latency_valid", 128'(o_line_valid), 128'(1));
    chk("drain_first_not_last", 128'(o_line_last), 128'(0));
    wait_idle();

    // Exactly 128 bits with last: a single last line, no flush.
    send_beat(34'h3_AAAA_5555, 34'h3_1234_ABCD, 6'd32, 6'd32, 1'b0);
    send_beat(34'h2_FFFF_0001, 34'h1_8000_0001, 6'd32, 6'd32, 1'b1);
    chk("exact_valid", 128'(o_line_valid), 128'(1));
    chk("exact_last", 128'(o_line_last), 128'(1));
    wait_idle();
    chk("no_flush_after_exact", 128'(o_line_valid), 128'(0));
    @(posedge i_clk); #1;
    chk("no_flush_after_exact_2", 128'(o_line_valid), 128'(0));

    // Back-pressure while draining.
    i_line_ready = 1'b0;
    send_beat(34'h1_1111_1111, 34'h2_2222_2222, 6'd34, 6'd34, 1'b0);
    send_beat(34'h3_3333_3333, 34'h0_4444_4444, 6'd34, 6'd34, 1'b0);
    line_cap = o_line;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      chk("stall_ready", 128'(o_ready), 128'(0));
      chk("stall_valid", 128'(o_line_valid), 128'(1));
      chk("stall_line", o_line, line_cap);
    end
    i_line_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("stall_released", 128'(o_line_valid), 128'(0));
    send_beat(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 6'd0, 6'd0, 1'b1);
    wait_idle();

    // Over-long length is clamped and latches the error flag.
    send_beat(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 6'd40, 6'd0, 1'b1);
    chk("len_err_set", 128'(o_len_err), 128'(1));
    wait_idle();
    chk("len_err_sticky", 128'(o_len_err), 128'(1));

    // Empty packet yields one all-zero last line.
    send_beat(34'h2_5A5A_5A5A, 34'h1_A5A5_A5A5, 6'd0, 6'd0, 1'b1);
    wait_idle();

    // Mixed lengths including zeros across several lines.
    for (int i = 0; i < 10; i++) begin
      send_beat(34'(64'(i + 1) * 64'h9E37_79B1), 34'(64'(i + 7) * 64'h85EB_CA6B),
                tl1[i], tl2[i], (i == 9) ? 1'b1 : 1'b0);
    end
    wait_idle();

    // Reset mid-packet at fill 100 discards everything.
    send_beat(34'h3_CAFE_F00D, 34'h0_BADC_0DE5, 6'd34, 6'd34, 1'b0);
    send_beat(34'h1_0123_4567, 34'h3_FFFF_FFFF, 6'd32, 6'd0, 1'b0);
    i_reset = 1'b0;
    #1;
    chk("midrst_ready_low", 128'(o_ready), 128'(0));
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    bitq.delete();
    pkt_cnt = 0;
    #1;
    chk("midrst_no_line", 128'(o_line_valid), 128'(0));
    chk("midrst_len_err_clear", 128'(o_len_err), 128'(0));
    chk("midrst_ready", 128'(o_ready), 128'(1));
    chk("midrst_pkt_clear", 128'(o_pkt_bits), 128'(0));
    send_beat(34'h0_1357_9BDF, 34'h2_2468_ACE0, 6'd32, 6'd32, 1'b1);
    wait_idle();
    repeat (3) @(posedge i_clk);
    #1;
    chk("final_idle", 128'(o_line_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
